seg7_scan: RTL and testbench
============================

# seg7_scan

Time-multiplexed driver for a 4-digit common-anode 7-segment display. It takes the four BCD digits produced by the decimal counter chain and turns them into a scanned anode/segment drive. Each digit is lit in turn with a one-cycle ghost-guard blank between digits. Inputs are snapshotted once per frame so a counter rollover never shows a torn value.

## Interface

Parameters:
- SCAN_DIV, default 50000: clk cycles per digit slot; minimum 2; counter width = clog2(SCAN_DIV).

Ports:
- clk  input  1  system clock, rising-edge; the only clock.
- rst  input  1  reset; one clock, reset is synchronous and active-high.
- d0  input  4  BCD ones digit.
- d1  input  4  BCD tens digit.
- d2  input  4  BCD hundreds digit.
- d3  input  4  BCD thousands digit.
- dp_in  input  4  decimal-point request per digit, active-high; bit i belongs to di.
- an  output  4  digit anode enables, active-low; an[i] lights digit i.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal point, active-low.

## Operation

- State:
  - div_cnt counts 0..SCAN_DIV-1 and wraps.
  - idx (2 bits) is the current digit.
  - snap holds the captured d3..d0 and dp_in.
- Digit advance: on the cycle div_cnt==SCAN_DIV-1, div_cnt goes to 0 and idx goes to idx+1 mod 4.
- Scan order is 0,1,2,3,0,… and one frame is 4*SCAN_DIV cycles.
- Snapshot: snap loads d0..d3 and dp_in on every cycle with div_cnt==0 and idx==0, i.e. the blank cycle of digit 0. Input changes at any other time are invisible until the next frame.
- Ghost guard: when div_cnt==0, the next an is 4'b1111, seg is 7'b1111111 and dp is 1.
- Otherwise:
  - an has only bit idx low.
  - seg is decode(snap digit idx).
  - dp is ~snap dp bit idx.
- Decode, active-low {g..a}:
  - 0 → 1000000
  - 1 → 1111001
  - 2 → 0100100
  - 3 → 0110000
  - 4 → 0011001
  - 5 → 0010010
  - 6 → 0000010
  - 7 → 1111000
  - 8 → 0000000
  - 9 → 0010000
  - 10–15 (invalid BCD) → 0111111, a dash.
- Reset values:
  - div_cnt=0, idx=0, snap=0.
  - an=4'b1111, seg=7'b1111111, dp=1.
- Reset mid-scan returns all state to the reset values on the next edge. The scan restarts at digit 0 with a fresh snapshot.

## Timing

- All outputs are registered. They reflect the div_cnt/idx/snap state of the previous cycle, so pipeline latency is 1 cycle.
- First rising edge with rst=0 (call it T0):
  - State is div_cnt=0, idx=0, and snap captures.
  - After T0, outputs are blank for one cycle.
  - From T0+1 onward, digit 0 is lit for SCAN_DIV-1 cycles.
- Each slot is 1 blank cycle followed by SCAN_DIV-1 lit cycles, with no gaps between slots.
- Snapshot-to-display latency is 1 cycle: the digit 0 lit period shows the values captured at its own blank cycle.
- With SCAN_DIV=2, each slot is 1 blank cycle plus 1 lit cycle.

## Configuration

- SEG7_LZB_EN defined: leading-zero blanking.
  - In its lit cycles, digit 3 is blanked if snap d3==0.
  - Digit 2 is blanked if d3==0 and d2==0.
  - Digit 1 is blanked if d3, d2 and d1 are all 0.
  - Digit 0 is never blanked.
  - A blanked digit drives an=4'b1111 and seg=7'b1111111. Its dp is also forced to 1.
  - Invalid codes count as non-zero.
- SEG7_LZB_EN undefined: every digit is always lit, and zeros show as 1000000.

## Test plan

- Reset (SCAN_DIV=4): hold rst for 3 cycles → an=1111, seg=1111111, dp=1 throughout and on the first cycle after release.
- Basic scan (SCAN_DIV=4): d3..d0=1,2,3,4 and dp_in=0010. Expected per slot, each 3 lit cycles after 1 blank:
  - an=1110, seg=0011001, dp=1.
  - an=1101, seg=0110000, dp=0.
  - an=1011, seg=0100100, dp=1.
  - an=0111, seg=1111001, dp=1.
  - The sequence repeats every 16 cycles.
- Tear-free: change d0 from 4 to 9 during the digit-2 slot → digit 0 still shows 0011001 in that frame's remaining slots. Digit 0 shows 0010000 only from the next frame's digit-0 slot.
- Invalid BCD: d1=4'hC → during the digit-1 slot, seg=0111111 and an=1101.
- Mid-scan reset: assert rst for 1 cycle during the digit-2 slot → the next cycle is blank, and the scan resumes at digit 0 with newly snapshotted inputs.
- Leading zeros: d3..d0=0,0,7,0.
  - With SEG7_LZB_EN: the digit-3 and digit-2 slots hold an=1111; digit 1 shows 1111000; digit 0 shows 1000000.
  - Without SEG7_LZB_EN: digits 3 and 2 show 1000000 with an=0111 and an=1011.

Source files
------------

// File: rtl/seg7_scan.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : seg7_scan                                                        |
// | Purpose : Time-multiplexed 4-digit common-anode 7-segment driver with a    |
// |           one-cycle ghost-guard blank per slot and a per-frame snapshot.   |
// | Option  : define SEG7_LZB_EN to enable leading-zero blanking.              |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module seg7_scan #(
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  input  logic [3:0] dp_in,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int            C_CW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [C_CW-1:0] C_DIV_LAST = C_CW'(SCAN_DIV - 1);
  localparam logic [6:0]    C_SEG_OFF  = 7'b1111111;
  localparam logic [3:0]    C_AN_OFF   = 4'b1111;

  logic [C_CW-1:0] div_cnt_q, div_cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [15:0]     snap_dig_q, snap_dig_d;   // {d3,d2,d1,d0}
  logic [3:0]      snap_dp_q, snap_dp_d;
  logic [3:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic            dp_q, dp_d;

  logic [3:0]      cur_digit;
  logic            lz_blank;

  // BCD to active-low {g,f,e,d,c,b,a}; invalid codes show a dash
  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b0111111;
    endcase
  endfunction

  // Slot counter, digit index and frame-start snapshot
  always_comb begin
    div_cnt_d  = div_cnt_q;
    idx_d      = idx_q;
    snap_dig_d = snap_dig_q;
    snap_dp_d  = snap_dp_q;
    if (div_cnt_q == C_DIV_LAST) begin
      div_cnt_d = '0;
      idx_d     = idx_q + 2'd1;
    end else begin
      div_cnt_d = div_cnt_q + C_CW'(1);
    end
    // Capture only in digit 0's blank cycle so a frame never mixes two values
    if ((div_cnt_q == '0) && (idx_q == 2'd0)) begin
      snap_dig_d = {d3, d2, d1, d0};
      snap_dp_d  = dp_in;
    end
  end

  // Select the snapshotted digit for the current slot
  always_comb begin
    cur_digit = snap_dig_q[{idx_q, 2'b00} +: 4];
  end

  // Leading-zero suppression: a digit blanks when it and all higher digits are 0
`ifdef SEG7_LZB_EN
  always_comb begin
    case (idx_q)
      2'd3:    lz_blank = (snap_dig_q[15:12] == 4'd0);
      2'd2:    lz_blank = (snap_dig_q[15:8] == 8'd0);
      2'd1:    lz_blank = (snap_dig_q[15:4] == 12'd0);
      default: lz_blank = 1'b0;
    endcase
  end
`else
  always_comb begin
    lz_blank = 1'b0;
  end
`endif

  // Next output drive: blank on the guard cycle or a suppressed digit, else lit
  always_comb begin
    an_d  = C_AN_OFF;
    seg_d = C_SEG_OFF;
    dp_d  = 1'b1;
    if ((div_cnt_q != '0) && !lz_blank) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = decode(cur_digit);
      dp_d  = ~snap_dp_q[idx_q];
    end
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q  <= '0;
      idx_q      <= 2'd0;
      snap_dig_q <= 16'd0;
      snap_dp_q  <= 4'd0;
      an_q       <= C_AN_OFF;
      seg_q      <= C_SEG_OFF;
      dp_q       <= 1'b1;
    end else begin
      div_cnt_q  <= div_cnt_d;
      idx_q      <= idx_d;
      snap_dig_q <= snap_dig_d;
      snap_dp_q  <= snap_dp_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_seg7_scan                                                     |
// | Purpose : Self-checking bench for seg7_scan (SCAN_DIV=4): vector table,    |
// |           directed corner sequences and random stimulus vs a frame model.  |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_seg7_scan;

  localparam int S = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] d0 = 4'd0, d1 = 4'd0, d2 = 4'd0, d3 = 4'd0, dp_in = 4'd0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  seg7_scan #(.SCAN_DIV(S)) dut (
    .clk(clk), .rst(rst), .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .dp_in(dp_in), .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: edge index since the last reset, plus frame snapshot
  int         mk = 0;
  int         msnap[4];
  int         mdp[4];
  logic [3:0] e_an;
  logic [6:0] e_seg;
  logic       e_dp;

  localparam logic [11:0] BLANK = {4'b1111, 7'b1111111, 1'b1};

  typedef struct {
    logic [15:0] dig;
    logic [3:0]  dpin;
    int          slot;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
  } vec_t;

  vec_t tbl[9];

  function automatic logic [6:0] ref_dec(input int v);
    case (v)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  // Predict outputs after the coming edge from edge count and frame snapshot
  task automatic model(input logic r);
    int k, slot;
    logic lz;
    e_an = 4'b1111; e_seg = 7'b1111111; e_dp = 1'b1;
    if (r) begin
      mk = 0;
      return;
    end
    k = mk;
    mk++;
    if (k % (4 * S) == 0) begin
      msnap[0] = int'(d0); msnap[1] = int'(d1);
      msnap[2] = int'(d2); msnap[3] = int'(d3);
      for (int j = 0; j < 4; j++) mdp[j] = int'(dp_in[j]);
    end
    if (k % S == 0) return;
    slot = (k / S) % 4;
    lz = 1'b0;
`ifdef SEG7_LZB_EN
    if (slot != 0) begin
      lz = 1'b1;
      for (int j = slot; j < 4; j++) if (msnap[j] != 0) lz = 1'b0;
    end
`endif
    if (lz) return;
    e_an  = 4'b1111 & ~(4'(1) << slot);
    e_seg = ref_dec(msnap[slot]);
    e_dp  = (mdp[slot] == 0);
  endtask

  task automatic cmp(input string nm, input logic [11:0] got, input logic [11:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got an=%b seg=%b dp=%b, required an=%b seg=%b dp=%b",
               nm, $time, got[11:8], got[7:1], got[0], exp[11:8], exp[7:1], exp[0]);
    end
  endtask

  task automatic step(input logic r);
    rst = r;
    model(r);
    @(posedge clk);
    #1;
    cmp("model", {an, seg, dp}, {e_an, e_seg, e_dp});
  endtask

  task automatic set_in(input logic [15:0] dig, input logic [3:0] dpin);
    {d3, d2, d1, d0} = dig;
    dp_in = dpin;
  endtask

  initial begin
    tbl[0] = '{16'h1234, 4'b0010, 0, 4'b1110, 7'b0011001, 1'b1};
    tbl[1] = '{16'h1234, 4'b0010, 1, 4'b1101, 7'b0110000, 1'b0};
    tbl[2] = '{16'h1234, 4'b0010, 2, 4'b1011, 7'b0100100, 1'b1};
    tbl[3] = '{16'h1234, 4'b0010, 3, 4'b0111, 7'b1111001, 1'b1};
    tbl[4] = '{16'h12C4, 4'b0000, 1, 4'b1101, 7'b0111111, 1'b1};
`ifdef SEG7_LZB_EN
    tbl[5] = '{16'h0070, 4'b1000, 3, 4'b1111, 7'b1111111, 1'b1};
    tbl[6] = '{16'h0070, 4'b0000, 2, 4'b1111, 7'b1111111, 1'b1};
`else
    tbl[5] = '{16'h0070, 4'b1000, 3, 4'b0111, 7'b1000000, 1'b0};
    tbl[6] = '{16'h0070, 4'b0000, 2, 4'b1011, 7'b1000000, 1'b1};
`endif
    tbl[7] = '{16'h0070, 4'b0000, 1, 4'b1101, 7'b1111000, 1'b1};
    tbl[8] = '{16'h0070, 4'b0000, 0, 4'b1110, 7'b1000000, 1'b1};

    // Reset held for three cycles, then release
    set_in(16'h1234, 4'b0010);
    for (int i = 0; i < 3; i++) begin
      step(1'b1);
      cmp("rst_hold", {an, seg, dp}, BLANK);
    end
    step(1'b0);                                   // edge 0: guard blank
    cmp("rst_release", {an, seg, dp}, BLANK);

    // Tear-free: d0 change inside the lit digit-0 slot stays invisible
    step(1'b0);                                   // edge 1
    cmp("lit_d0", {an, seg, dp}, {4'b1110, 7'b0011001, 1'b1});
    d0 = 4'd9;
    step(1'b0);                                   // edge 2
    cmp("tear_in_slot", {an, seg, dp}, {4'b1110, 7'b0011001, 1'b1});
    for (int k = 3; k <= 4 * S + 1; k++) step(1'b0);
    cmp("tear_next_frame", {an, seg, dp}, {4'b1110, 7'b0010000, 1'b1});

    // Mid-scan reset during the digit-2 slot
    for (int k = 4 * S + 2; k <= 6 * S + 1; k++) step(1'b0);
    cmp("pre_mrst_d2", {an, seg, dp}, {4'b1011, 7'b0100100, 1'b1});
    set_in(16'h5678, 4'b0001);
    step(1'b1);
    cmp("mrst_blank", {an, seg, dp}, BLANK);
    step(1'b0);
    cmp("mrst_t0", {an, seg, dp}, BLANK);
    step(1'b0);
    cmp("mrst_resume", {an, seg, dp}, {4'b1110, 7'b0000000, 1'b0});

    // Vector table: each entry checked over its slot's lit cycles
    for (int i = 0; i < 9; i++) begin
      step(1'b1);
      step(1'b1);
      set_in(tbl[i].dig, tbl[i].dpin);
      for (int k = 0; k < tbl[i].slot * S + S; k++) begin
        step(1'b0);
        if (k >= tbl[i].slot * S + 1)
          cmp($sformatf("tbl%0d", i), {an, seg, dp}, {tbl[i].an, tbl[i].seg, tbl[i].dp});
        else if (k == tbl[i].slot * S)
          cmp($sformatf("tbl%0d_guard", i), {an, seg, dp}, BLANK);
      end
    end

    // Random stimulus against the frame model
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        d0 = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        d1 = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        d2 = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        d3 = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        dp_in = 4'($urandom_range(0, 15));
      end
      step($urandom_range(0, 59) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
